// File: rtl/conv_1d_seq.sv
// conv_1d_seq: line sequencer + K-tap MAC for 1-D convolution of signed bytes.
// One line of D samples in, D filtered samples out, with reflect padding at
// both line edges, taken from a K-deep sample window (no line buffer).
// Optional build macro CONV1D_SAT_EN: saturate the output to [-128,127]
// instead of keeping the low byte of the accumulator.
module conv_1d_seq #(
  parameter int D = 640,
  parameter int K = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 kern_we,
  input  logic [$clog2(K)-1:0] kern_addr,
  input  logic [7:0]           kern_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data
);

  localparam int H  = K / 2;
  localparam int AW = 16 + $clog2(K) + 1;
  localparam int CW = $clog2(D + 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t             state;
  logic signed [7:0]  kern [K];
  logic signed [7:0]  win  [K];
  logic [CW-1:0]      in_cnt;
  logic [CW-1:0]      out_cnt;

  logic               out_free;
  logic               in_fire;
  logic               out_fire;
  logic               load;
  logic signed [7:0]  src  [K+1];
  logic signed [7:0]  tap  [K];
  logic signed [15:0] prod [K];
  logic signed [AW-1:0] acc;
  logic [7:0]         result;
  int                 ref_idx;

  assign out_free = !out_valid || out_ready;
  assign in_ready = ((state == FILL) || (state == RUN)) && out_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // A new output is produced for every sample accepted in RUN, and once per
  // free output slot in DRAIN until all D outputs have been loaded.
  assign load = ((state == RUN) && in_fire) ||
                ((state == DRAIN) && out_free && (out_cnt != CW'(D)));

  // Kernel coefficients are writable only while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < K; j++) kern[j] <= '0;
    end else if (kern_we && (state == IDLE) && (int'(kern_addr) < K)) begin
      kern[kern_addr] <= kern_data;
    end
  end

  // Window of the last K accepted samples; win[0] is the newest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < K; a++) win[a] <= '0;
    end else if (in_fire) begin
      win[0] <= in_data;
      for (int a = 1; a < K; a++) win[a] <= win[a-1];
    end
  end

  // Sample sources by age: src[0] is the sample being accepted this cycle.
  always_comb begin
    src[0] = in_data;
    for (int a = 0; a < K; a++) src[a+1] = win[a];
  end

  // Age reference: in RUN the incoming sample has index in_cnt; in DRAIN
  // win[0] holds sample D-1, which is src[1], so the reference is D.
  always_comb begin
    ref_idx = (state == DRAIN) ? D : int'(in_cnt);
  end

  // Per tap: reflect the position into the line, convert the sample index to
  // an age in the window, and multiply with the tap coefficient.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_tap
      int p;
      int q;
      int idx;
      always_comb begin
        p = int'(out_cnt) - H + gi;
        if (p < 0)
          q = -p;
        else if (p > D - 1)
          q = 2 * (D - 1) - p;
        else
          q = p;
        idx = ref_idx - q;
        tap[gi] = '0;
        for (int a = 0; a <= K; a++) begin
          if (idx == a) tap[gi] = src[a];
        end
        prod[gi] = tap[gi] * kern[gi];
      end
    end
  endgenerate

  // Full-width sum of the tap products, then reduce to a byte.
  always_comb begin
    acc = '0;
    for (int j = 0; j < K; j++) begin
      acc = acc + {{(AW-16){prod[j][15]}}, prod[j]};
    end
`ifdef CONV1D_SAT_EN
    if (!acc[AW-1] && (|acc[AW-2:7]))
      result = 8'h7f;
    else if (acc[AW-1] && !(&acc[AW-2:7]))
      result = 8'h80;
    else
      result = acc[7:0];
`else
    result = acc[7:0];
`endif
  end

  // Line sequencer: state, counters, status flags and the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (out_fire) out_valid <= 1'b0;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= result;
        out_cnt   <= out_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FILL;
            busy    <= 1'b1;
            in_cnt  <= '0;
            out_cnt <= '0;
          end
        end
        FILL: begin
          if (in_fire) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == CW'(H - 1)) state <= RUN;
          end
        end
        RUN: begin
          if (in_fire) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == CW'(D - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_fire && (out_cnt == CW'(D))) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_1d_seq.md
Name: conv_1d_seq

Overview:
- Streaming sequencer and MAC engine for 1-D line convolution over signed byte samples.
- Owns a programmable K-tap kernel register file and accepts one line of D samples over a valid/ready input.
- Emits D filtered samples over a valid/ready output, applying mirror (reflect) padding at both line edges.
- Sits between the pixel line source and the row/column stages of the image convolution pipeline; sequences one line per start.

Parameters:
D, 640, samples per line; D >= K
K, 3, kernel taps; odd, >= 3; H = K/2 (integer) is the half-width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
kern_we  in  1  kernel coefficient write strobe
kern_addr  in  $clog2(K)  coefficient index 0..K-1; addresses >= K ignored
kern_data  in  8  signed coefficient
start  in  1  begin a line; sampled in IDLE only
busy  out  1  high from start acceptance through final output handshake
done  out  1  one-cycle pulse after the final output handshake of a line
in_valid  in  1  input sample valid
in_ready  out  1  input sample accepted when in_valid && in_ready
in_data  in  8  signed input sample
out_valid  out  1  output sample valid; held until accepted
out_ready  in  1  downstream ready
out_data  out  8  signed output sample; stable while out_valid && !out_ready

Behaviour:
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0. Kernel regs, window, and counters are all 0. State is IDLE.
- Reset mid-line aborts immediately. The partial line is discarded, with no done pulse.
- FSM transitions:
  - IDLE -> FILL on start. busy rises the next cycle.
  - FILL: accept samples 0..H-1; no output. Go to RUN after sample H-1 is accepted.
  - RUN: accepting sample n (H <= n <= D-1) loads output n-H into the output register on the same edge, so out_valid is seen the next cycle. Go to DRAIN after sample D-1 is accepted.
  - DRAIN: produce outputs D-H..D-1, one per cycle, whenever the output register is free. No input accepted.
  - DRAIN -> IDLE on the final output handshake. done pulses on the following cycle and busy drops the same cycle.
- in_ready = (FILL or RUN) && (!out_valid || out_ready). in_ready is never high in IDLE or DRAIN.
- Output register: single entry, loaded when empty or being drained the same cycle. out_valid falls only on handshake or reset.
- Reflect index for output i, tap j:
  - Position p = i - H + j.
  - If p < 0, use data[-p].
  - If p > D-1, use data[2(D-1) - p].
  - Otherwise use data[p].
- Window: the last K accepted samples are held in a shift register. Edge taps are muxed from it; no line buffer.
- Arithmetic:
  - Signed 8x8 products.
  - Sum in a full-width accumulator of at least 16 + $clog2(K) bits.
  - out_data = accumulator[7:0] (two's-complement wrap).
- Kernel writes:
  - Accepted only in IDLE. kern_we is ignored while busy.
  - A write in the same cycle as start takes effect for that line.
- start while busy is ignored. Simultaneous start and rst: reset wins.
- Throughput: 1 sample/cycle with no backpressure. A line takes D + 1 cycles from the first input handshake to the last output valid.

Optional Feature:
- Macro: CONV1D_SAT_EN.
- Defined: out_data is the accumulator saturated to [-128, 127].
- Undefined: low-byte wrap as above.

Test Plan:
- K=3, D=8, kernel [1,2,1], data 1..8, out_ready=1 -> outputs 6,8,12,16,20,24,28,30. done pulses once; busy low afterwards.
- Kernel [0,1,0], data 10..17 -> outputs 10..17. First out_valid is the cycle after the handshake of sample 1; last out_valid is 9 cycles after the first input handshake.
- Kernel [0,127,0], one sample 2 mid-line -> out_data 0xFE (-2). With CONV1D_SAT_EN, out_data 0x7F.
- Kernel [1,2,1], data 1..8, out_ready held low 5 cycles mid-line:
  - in_ready stays low.
  - out_data is stable.
  - The output sequence is unchanged; no loss or duplication.
- kern_we addr 1 data 5 while busy -> ignored; the line result matches kernel [1,2,1]. The same write in IDLE takes effect on the next line.
- rst asserted after 4 inputs -> all outputs 0 and state IDLE with no done. A new start and full line then give the first scenario's outputs.
